regfile_wb_arbiter: RTL

- Shares the single register-file write port (i_write_en_3 / i_addr_3 / i_write_data_3) between two requesters.
  - Primary: the in-order pipeline writeback.
  - Secondary: long-latency result producers, such as mul/div and future units.
- Secondary results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation counter forces a one-cycle pipeline stall when the FIFO is starved.
- Per-register pending flags are exported so the hazard logic can stall dependent instructions in decode.

---
 rtl/regfile_wb_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results
// are buffered in a FIFO and drained into idle slots. Optional stats: REGFILE_WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH   = 64,
   parameter int REG_ADDR_W   = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          i_clk,
   input  logic                          i_arst,
   input  logic                          i_wb_we,
   input  logic [REG_ADDR_W-1:0]         i_wb_addr,
   input  logic [DATA_WIDTH-1:0]         i_wb_data,
   input  logic                          i_lu_valid,
   output logic                          o_lu_ready,
   input  logic [REG_ADDR_W-1:0]         i_lu_addr,
   input  logic [DATA_WIDTH-1:0]         i_lu_data,
   input  logic [REG_ADDR_W-1:0]         i_rs1_addr,
   input  logic [REG_ADDR_W-1:0]         i_rs2_addr,
   output logic                          o_rs1_pending,
   output logic                          o_rs2_pending,
   output logic                          o_stall_wb,
   output logic                          o_reg_we,
   output logic [REG_ADDR_W-1:0]         o_rd_addr,
   output logic [DATA_WIDTH-1:0]         o_rd_write_data,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
`ifdef REGFILE_WB_ARB_STATS_EN
   ,
   output logic [31:0]                   o_conflict_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

   logic [REG_ADDR_W-1:0] mem_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_vld;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count, count_nxt;
   logic [ST_W-1:0]       starve_cnt, starve_nxt;

   logic fifo_nempty, force_grant, wb_ok, pop, store;
   logic rs1_hit, rs2_hit;

   assign fifo_nempty = (count != '0);
   assign wb_ok       = i_wb_we && (i_wb_addr != '0);

   always_comb begin
      o_lu_ready      = 1'b0;
      o_stall_wb      = 1'b0;
      o_reg_we        = 1'b0;
      o_rd_addr       = '0;
      o_rd_write_data = '0;
      force_grant     = 1'b0;
      pop             = 1'b0;
      store           = 1'b0;
      if (!i_arst) begin
         o_lu_ready  = (count != CNT_W'(FIFO_DEPTH));
         store       = i_lu_valid && o_lu_ready && (i_lu_addr != '0);
         force_grant = fifo_nempty && (starve_cnt == ST_W'(STARVE_LIMIT));
         if (force_grant) begin
            pop             = 1'b1;
            o_stall_wb      = 1'b1;
            o_reg_we        = 1'b1;
            o_rd_addr       = mem_addr[rd_ptr];
            o_rd_write_data = mem_data[rd_ptr];
         end else if (wb_ok) begin
            o_reg_we        = 1'b1;
            o_rd_addr       = i_wb_addr;
            o_rd_write_data = i_wb_data;
         end else if (fifo_nempty) begin
            pop             = 1'b1;
            o_reg_we        = 1'b1;
            o_rd_addr       = mem_addr[rd_ptr];
            o_rd_write_data = mem_data[rd_ptr];
         end
      end
   end

   // The head being popped this cycle stays pending: the register file only updates at the edge.
   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (mem_vld[i] && (mem_addr[i] == i_rs1_addr)) rs1_hit = 1'b1;
         if (mem_vld[i] && (mem_addr[i] == i_rs2_addr)) rs2_hit = 1'b1;
      end
   end

   assign o_rs1_pending = rs1_hit && (i_rs1_addr != '0) && !i_arst;
   assign o_rs2_pending = rs2_hit && (i_rs2_addr != '0) && !i_arst;
   assign o_fifo_count  = count;

   always_comb begin
      count_nxt = count;
      case ({store, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      starve_nxt = starve_cnt;
      if (!fifo_nempty || pop)
         starve_nxt = '0;
      else if (starve_cnt != ST_W'(STARVE_LIMIT))
         starve_nxt = starve_cnt + ST_W'(1);
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         mem_vld    <= '0;
      end else begin
         if (pop) begin
            mem_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         if (store) begin
            mem_vld[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         count      <= count_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Payload storage needs no reset; the valid bits and count qualify it.
   always_ff @(posedge i_clk) begin
      if (store) begin
         mem_addr[wr_ptr] <= i_lu_addr;
         mem_data[wr_ptr] <= i_lu_data;
      end
   end

`ifdef REGFILE_WB_ARB_STATS_EN
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)
         o_conflict_cnt <= '0;
      else if (wb_ok && fifo_nempty)
         o_conflict_cnt <= o_conflict_cnt + 32'd1;
   end
`endif

endmodule
